// File: rtl/input_entry_unit.sv
// Push-button entry stage: synchronizes and debounces an active-low key and, on each
// accepted press, captures the signed switch value into the next slot of a small read-indexed file.
module input_entry_unit #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int NUM_ENTRIES     = 6,
  parameter int DATA_W          = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              key_ni,
  input  logic [DATA_W-1:0] sw_data_i,
  input  logic [2:0]        rd_idx_i,
  output logic [31:0]       rd_data_o,
  output logic [2:0]        count_o,
  output logic              full_o,
  output logic              overflow_o,
  output logic              commit_pulse_o
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            key_s1;
  logic            key_s;
  logic            stable;
  logic [DB_W-1:0] deb_cnt;
  logic            press;

  // Count is one bit wider than count_o so that a full 8-entry file is still distinguishable.
  logic [3:0]      count;
  logic [31:0]     slots [8];

  assign full_o  = (count == 4'(NUM_ENTRIES));
  assign count_o = count[2:0];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      key_s1  <= 1'b1;
      key_s   <= 1'b1;
      stable  <= 1'b1;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      key_s1 <= key_ni;
      key_s  <= key_s1;
      press  <= 1'b0;
      if (key_s == stable) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DB_MAX) begin
        // Accept the new level; only a falling (press) transition raises an event.
        stable  <= key_s;
        deb_cnt <= '0;
        press   <= ~key_s;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  // NOTE: the entry file is tiny and its zero state is architecturally visible, so it is reset
  // like ordinary flops rather than left as uninitialized RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 8; i++) slots[i] <= '0;
      count          <= '0;
      overflow_o     <= 1'b0;
      commit_pulse_o <= 1'b0;
      rd_data_o      <= '0;
    end else begin
      commit_pulse_o <= 1'b0;
      rd_data_o      <= ({1'b0, rd_idx_i} < 4'(NUM_ENTRIES)) ? slots[rd_idx_i] : '0;
      if (clear_i) begin
        for (int i = 0; i < 8; i++) slots[i] <= '0;
        count      <= '0;
        overflow_o <= 1'b0;
      end else if (press && en_i) begin
        if (full_o) begin
          overflow_o <= 1'b1;
        end else begin
          slots[count[2:0]] <= 32'($signed(sw_data_i));
          count             <= count + 4'd1;
          commit_pulse_o    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/input_entry_unit.md
Name: input_entry_unit

Overview:
- Upstream input stage between the board switches/push-button and the processor's memory-mapped input port.
- Synchronizes and debounces the active-low push-button key.
- On each debounced press, captures the 16-bit signed switch value into the next slot of a small entry file, sign-extended to 32 bits.
- The processor reads the slots by index. Slots hold the coordinate inputs xA, yA, xB, yB, xC, yC.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive stable cycles required to accept a key level change (1_000_000 for board build).
- NUM_ENTRIES, 6, number of capture slots (max 8).
- DATA_W, 16, switch data width.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- en_i  input  1  capture enable (SW[17])
- clear_i  input  1  synchronous clear of entry file and counters
- key_ni  input  1  raw push-button, active-low (0 = pressed), asynchronous
- sw_data_i  input  DATA_W  raw switch value, two's complement
- rd_idx_i  input  3  slot index for read
- rd_data_o  output  32  registered, sign-extended slot contents
- count_o  output  3  number of filled slots
- full_o  output  1  count_o == NUM_ENTRIES
- overflow_o  output  1  sticky: press accepted while full
- commit_pulse_o  output  1  one-cycle strobe when a slot is written

Behaviour:
- **Reset** (rst_i high at edge):
  - sync flops = 1, stable key = 1 (released), debounce counter = 0.
  - All slots = 0, count_o = 0, full_o = 0, overflow_o = 0, commit_pulse_o = 0, rd_data_o = 0.
- **Synchronizer:** 2-FF on key_ni; only the stage-2 output (key_s) is used.
- **Debounce:**
  - Counter increments each cycle key_s != stable.
  - Counter resets to 0 on any cycle key_s == stable.
  - When the counter reaches DEBOUNCE_CYCLES-1 and key_s still differs, stable takes key_s and the counter resets.
- **Press event:** stable transitions 1->0, registered. The release transition (0->1) generates nothing.
- **Latency:** edge 0 is the first edge sampling the new low key_ni. The slot write, count increment and commit_pulse_o high all occur at edge DEBOUNCE_CYCLES+2, provided key_ni is held low throughout.
- **Commit:** on a press event with en_i=1 and full_o=0:
  - slot[count] <= sign_extend(sw_data_i), sampled at the commit edge.
  - count <= count+1.
  - commit_pulse_o = 1 for exactly one cycle.
- **Press while full** (en_i=1): no slot changes, count holds, commit_pulse_o stays 0, overflow_o set (sticky).
- **Press with en_i=0:** ignored entirely (no write, no overflow). Debounce still tracks the key, so a press held across an en_i rise does not commit.
- **clear_i:** at the edge it is high:
  - all slots = 0, count = 0, overflow_o = 0.
  - Debounce state is untouched.
  - clear_i and a press event on the same edge: clear wins, no commit, commit_pulse_o = 0.
- **full_o:** combinational from count.
- **Read:** rd_data_o <= slot[rd_idx_i] each cycle, one-cycle latency.
  - rd_idx_i >= NUM_ENTRIES returns 0.
  - A read of the slot being written on the same edge returns the old value; the new value appears the next cycle.
- **Reset mid-debounce:** counter and stable are reinitialized; a key already low after reset must satisfy the full DEBOUNCE_CYCLES again and produces a press event (stable starts released).

Test Plan:
- **Six-value capture.** Setup: reset, en_i=1, 20 ns clock. Stimulus: six press/release pairs, each held 100 cycles, with sw_data_i = 93, -346, -88, -493, 26, -257. Required:
  - rd_idx 0..5 read 0x0000005D, 0xFFFFFEA6, 0xFFFFFFA8, 0xFFFFFE13, 0x0000001A, 0xFFFFFEFF.
  - count_o=6, full_o=1.
  - Exactly six commit_pulse_o strobes.
- **Latency and bounce.**
  - key_ni low continuously from edge 0: commit_pulse_o high exactly after edge 18 (DEBOUNCE_CYCLES=16).
  - key_ni low 10 cycles, high 3, low 30: exactly one commit, 18 edges after the start of the 30-cycle run.
- **Overflow.** After six commits, a 7th press with sw_data_i=5 -> slot 5 still 0xFFFFFEFF, count_o=6, overflow_o=1, no strobe. Then clear_i -> count_o=0, overflow_o=0, all reads return 0.
- **Enable gating.**
  - Press with en_i=0 -> no commit.
  - Raise en_i while the key is still held -> no commit.
  - Release, then press again -> commit into slot 0.
- **Clear collision.** clear_i asserted on the exact commit edge of a press -> count_o=0, slot 0 reads 0, commit_pulse_o stays 0.
- **Reset mid-debounce.** rst_i pulsed 8 cycles into a press with the key still low -> no commit until 16+2 edges after reset release; then one commit.
